// File: rtl/reg_64b_wr_fifo.sv
// reg_64b_wr_fifo: in-order write-staging FIFO in front of reg_64b.
// Producers push over valid/ready. Entries drain one per cycle as a
// wr_en/wr_data pair. Fullness is tracked by an explicit count, so the
// pointers wrap freely and are never compared against each other.
module reg_64b_wr_fifo #(
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = 3,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [63:0]   in_data,
    input  logic          stall,
    input  logic          flush,
    output logic          wr_en,
    output logic [63:0]   wr_data,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          almost_full
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          push;
    logic          pop;

    // Status flags come only from the registered count. A pop in the
    // same cycle does not raise in_ready, so there is no pass-through path.
    assign empty       = (count_reg == '0);
    assign full        = (count_reg == DEPTH_C);
    assign almost_full = (count_reg >= AF_C);
    assign in_ready    = !full;
    assign count       = count_reg;

    // Flush discards the same-cycle push and blocks the pop, even
    // when stall is low.
    assign push    = in_valid & in_ready & !flush;
    assign wr_en   = !empty & !stall & !flush;
    assign pop     = wr_en;
    assign wr_data = empty ? 64'h0 : mem[rd_ptr_reg];

    // Occupancy update: push and pop in the same cycle cancel each other.
    always_comb begin
        count_next = count_reg + CW'(push) - CW'(pop);
    end

    // Pointer and count registers. Reset is asynchronous; flush is synchronous.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            count_reg <= count_next;
        end
    end

    // Storage array has no reset; entries are only visible through count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= in_data;
    end

endmodule

// File: tb/tb_reg_64b_wr_fifo.sv
// Directed self-checking bench for reg_64b_wr_fifo, with a reg_64b model
// on the write port.
module tb_reg_64b_wr_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        stall;
    logic        flush;
    logic        wr_en;
    logic [63:0] wr_data;
    logic [2:0]  count;
    logic        empty;
    logic        full;
    logic        almost_full;
    logic [63:0] reg_q;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] ONES = 64'h1111_1111_1111_1111;
    localparam logic [63:0] SEQB = 64'hC0DE_0000_0000_0000;

    reg_64b_wr_fifo #(.DEPTH(4), .AF_LEVEL(3), .CW(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .stall(stall), .flush(flush), .wr_en(wr_en),
        .wr_data(wr_data), .count(count), .empty(empty), .full(full),
        .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    // reg_64b model: captures wr_data on each enabled rising edge
    always @(posedge clk or negedge rst) begin
        if (!rst)       reg_q <= 64'h0;
        else if (wr_en) reg_q <= wr_data;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end else begin
            $display("ok   %s = %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] last;
        rst = 1'b0; in_valid = 1'b1; in_data = 64'hAAAA_AAAA_AAAA_AAAA;
        stall = 1'b0; flush = 1'b0;

        // Reset held with in_valid high
        tick(); tick(); tick();
        check("rst_wr_en", wr_en, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_wr_data", wr_data, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_af", almost_full, 0);
        check("rst_reg", reg_q, 0);

        // Release, then first push appears one cycle later
        in_valid = 1'b0;
        #3 rst = 1'b1;
        tick();
        in_valid = 1'b1; in_data = 64'h0123_4567_89AB_CDEF;
        tick();
        in_valid = 1'b0;
        check("first_wr_data", wr_data, 64'h0123_4567_89AB_CDEF);
        check("first_wr_en", wr_en, 1);
        check("first_count", count, 1);
        tick();
        check("first_reg", reg_q, 64'h0123_4567_89AB_CDEF);
        check("first_empty", empty, 1);

        // Fill under stall
        stall = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1; in_data = ONES * i;
            #1 check("fill_ready", in_ready, 1);
            tick();
            check("fill_count", count, 64'(i));
            check("fill_af", almost_full, (i >= 3) ? 1 : 0);
            check("fill_full", full, (i == 4) ? 1 : 0);
            check("fill_stall_wr_en", wr_en, 0);
            check("fill_stable_data", wr_data, ONES);
        end
        in_data = 64'h5555_5555_5555_5555;
        #1 check("full_not_ready", in_ready, 0);
        tick();
        check("full_hold_count", count, 4);
        in_valid = 1'b0;

        // Drain in order
        stall = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            #1 check("drain_wr_en", wr_en, 1);
            check("drain_wr_data", wr_data, ONES * i);
            tick();
        end
        check("drain_empty", empty, 1);
        check("drain_wr_en_low", wr_en, 0);
        check("drain_reg", reg_q, 64'h4444_4444_4444_4444);

        // Simultaneous push and pop at count=2
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = SEQB + 64'(k);
            tick();
        end
        stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            in_valid = 1'b1; in_data = SEQB + 64'(k + 2);
            #1 check("pp_count", count, 2);
            check("pp_wr_en", wr_en, 1);
            check("pp_wr_data", wr_data, SEQB + 64'(k));
            tick();
        end
        in_valid = 1'b0;
        for (int k = 20; k < 22; k++) begin
            #1 check("pp_tail_data", wr_data, SEQB + 64'(k));
            tick();
        end
        check("pp_empty", empty, 1);
        last = SEQB + 64'd21;
        check("pp_reg", reg_q, last);

        // Flush at count=3 with a push offered
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            in_valid = 1'b1; in_data = 64'hF000_0000_0000_0000 + 64'(k);
            tick();
        end
        check("pre_flush_count", count, 3);
        stall = 1'b0; flush = 1'b1; in_valid = 1'b1;
        in_data = 64'hDEAD_DEAD_DEAD_DEAD;
        #1 check("flush_wr_en", wr_en, 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        check("flush_wr_data", wr_data, 0);
        check("flush_reg", reg_q, last);
        in_valid = 1'b1; in_data = 64'hBEEF_BEEF_BEEF_BEEF;
        tick();
        in_valid = 1'b0;
        check("post_flush_data", wr_data, 64'hBEEF_BEEF_BEEF_BEEF);
        check("post_flush_count", count, 1);
        tick();
        check("post_flush_reg", reg_q, 64'hBEEF_BEEF_BEEF_BEEF);

        // Asynchronous reset mid-burst at count=2
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 64'h9000_0000_0000_0000 + 64'(k);
            tick();
        end
        in_valid = 1'b0; stall = 1'b0;
        check("pre_arst_count", count, 2);
        #2 rst = 1'b0;
        #1 check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        check("arst_wr_en", wr_en, 0);
        check("arst_wr_data", wr_data, 0);
        check("arst_in_ready", in_ready, 1);
        tick();
        check("arst_hold_wr_en", wr_en, 0);
        #3 rst = 1'b1;
        tick();
        check("rel_empty", empty, 1);
        check("rel_wr_data", wr_data, 0);
        in_valid = 1'b1; in_data = 64'h7777_7777_7777_7777;
        tick();
        in_valid = 1'b0;
        check("rel_push_data", wr_data, 64'h7777_7777_7777_7777);
        check("rel_push_count", count, 1);
        tick();
        check("rel_reg", reg_q, 64'h7777_7777_7777_7777);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
